vec_mem_stage: RTL and testbench



---
 rtl/interfaces_def_pkg.sv | 17 +
 rtl/vmem_watchdog.sv | 44 ++++
 rtl/vec_mem_stage.sv | 172 +++++++++++++++++
 tb/tb_vec_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interfaces_def_pkg.sv
// Shared definitions for the vector memory stage.
//   vec_mem_state_e : FSM encoding of vec_mem_stage (also driven on its debug port)
//   VMEM_TIMEOUT    : default number of WAIT_RDY cycles before an access is abandoned
//   VMEM_CNT_W      : watchdog counter width, wide enough for the largest legal TIMEOUT (255)
package interfaces_def_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2,
        RESP     = 2'd3
    } vec_mem_state_e;

    localparam int VMEM_TIMEOUT = 16;
    localparam int VMEM_CNT_W   = 8;

endpackage

// File: rtl/vmem_watchdog.sv
// Cycle counter that flags an outstanding memory access taking too long.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (held while no access is outstanding)
//   enable     : count one cycle of waiting
//   expired    : high in the cycle that would bring the count to TIMEOUT,
//                so the owner can abort on that same clock edge
// TIMEOUT must lie in 4..255 so that it fits the VMEM_CNT_W-bit counter.
module vmem_watchdog
    import interfaces_def_pkg::*;
#(
    parameter int TIMEOUT = VMEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [VMEM_CNT_W-1:0] cnt_q;
    logic [VMEM_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The count during the N-th waiting cycle is N-1; the N-th edge is the
    // one on which the count reaches TIMEOUT.
    assign expired = enable && !clear && (cnt_q == VMEM_CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vec_mem_stage.sv
// MEM stage of a vector pipeline: hands one load/store at a time to the
// vector memory unit and returns the result through the MEM/WB register.
//   in_*       : instruction from EX; in_ready is high only in IDLE (stall otherwise)
//   mem_*      : start pulse and held operands to the memory unit, mem_ready/mem_rdata back
//   out_*      : MEM/WB register; out_valid pulses once per instruction
//   err_*      : sticky error flags, cleared only by reset
//   dbg_state  : current FSM state
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready;
// the memory unit is started by a one-cycle mem_start and answers with a
// one-cycle mem_ready, which is only looked at while waiting for it.
module vec_mem_stage
    import interfaces_def_pkg::*;
#(
    parameter int TIMEOUT = VMEM_TIMEOUT,
    parameter int VRD_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_is_load,
    input  logic             in_is_store,
    input  logic [31:0]      in_addr,
    input  logic [63:0]      in_vdata,
    input  logic [VRD_W-1:0] in_vrd,
    output logic             in_ready,
    output logic             mem_start,
    output logic [31:0]      mem_addr,
    output logic [63:0]      mem_wdata,
    output logic             mem_wr_en,
    input  logic             mem_ready,
    input  logic [63:0]      mem_rdata,
    output logic             out_valid,
    output logic             out_wb_en,
    output logic [VRD_W-1:0] out_vrd,
    output logic [63:0]      out_data,
    output logic             err_timeout,
    output logic             err_illegal,
    output vec_mem_state_e   dbg_state
);

    vec_mem_state_e   state_q, state_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [63:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [VRD_W-1:0] hold_vrd_q, hold_vrd_d;
    logic             hold_load_q, hold_load_d;
    logic             out_valid_q, out_valid_d;
    logic             out_wb_en_q, out_wb_en_d;
    logic [VRD_W-1:0] out_vrd_q, out_vrd_d;
    logic [63:0]      out_data_q, out_data_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_illegal_q, err_illegal_d;
    logic             wd_expired;

    vmem_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state_q != WAIT_RDY),
        .enable  (state_q == WAIT_RDY),
        .expired (wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wr_en_d   = mem_wr_en_q;
        hold_vrd_d    = hold_vrd_q;
        hold_load_d   = hold_load_q;
        out_valid_d   = 1'b0;
        out_wb_en_d   = 1'b0;
        out_vrd_d     = out_vrd_q;
        out_data_d    = out_data_q;
        err_timeout_d = err_timeout_q;
        err_illegal_d = err_illegal_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_is_load ^ in_is_store) begin
                        mem_addr_d  = in_addr;
                        mem_wdata_d = in_vdata;
                        mem_wr_en_d = in_is_store;
                        hold_vrd_d  = in_vrd;
                        hold_load_d = in_is_load;
                        state_d     = ISSUE;
                    end else begin
                        // Non-memory (or contradictory) op passes straight
                        // through with nothing to write back.
                        out_valid_d = 1'b1;
                        if (in_is_load && in_is_store) begin
                            err_illegal_d = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT_RDY;
            end
            WAIT_RDY: begin
                // A completion on the expiry edge still counts as success.
                if (mem_ready) begin
                    out_valid_d = 1'b1;
                    out_wb_en_d = hold_load_q;
                    out_vrd_d   = hold_vrd_q;
                    out_data_d  = mem_rdata;
                    state_d     = RESP;
                end else if (wd_expired) begin
                    err_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    out_vrd_d     = hold_vrd_q;
                    out_data_d    = '0;
                    state_d       = RESP;
                end
            end
            RESP: begin
                // Write enable must not linger once the access is finished.
                mem_wr_en_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wr_en_q   <= 1'b0;
            hold_vrd_q    <= '0;
            hold_load_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_wb_en_q   <= 1'b0;
            out_vrd_q     <= '0;
            out_data_q    <= '0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wr_en_q   <= mem_wr_en_d;
            hold_vrd_q    <= hold_vrd_d;
            hold_load_q   <= hold_load_d;
            out_valid_q   <= out_valid_d;
            out_wb_en_q   <= out_wb_en_d;
            out_vrd_q     <= out_vrd_d;
            out_data_q    <= out_data_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign mem_start   = (state_q == ISSUE);
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign out_valid   = out_valid_q;
    assign out_wb_en   = out_wb_en_q;
    assign out_vrd     = out_vrd_q;
    assign out_data    = out_data_q;
    assign err_timeout = err_timeout_q;
    assign err_illegal = err_illegal_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_vec_mem_stage.sv
module tb_vec_mem_stage;
    import interfaces_def_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int VRD_W   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_is_load;
    logic             in_is_store;
    logic [31:0]      in_addr;
    logic [63:0]      in_vdata;
    logic [VRD_W-1:0] in_vrd;
    logic             in_ready;
    logic             mem_start;
    logic [31:0]      mem_addr;
    logic [63:0]      mem_wdata;
    logic             mem_wr_en;
    logic             mem_ready;
    logic [63:0]      mem_rdata;
    logic             out_valid;
    logic             out_wb_en;
    logic [VRD_W-1:0] out_vrd;
    logic [63:0]      out_data;
    logic             err_timeout;
    logic             err_illegal;
    vec_mem_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    vec_mem_stage #(
        .TIMEOUT (TIMEOUT),
        .VRD_W   (VRD_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_addr     (in_addr),
        .in_vdata    (in_vdata),
        .in_vrd      (in_vrd),
        .in_ready    (in_ready),
        .mem_start   (mem_start),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wr_en   (mem_wr_en),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_wb_en   (out_wb_en),
        .out_vrd     (out_vrd),
        .out_data    (out_data),
        .err_timeout (err_timeout),
        .err_illegal (err_illegal),
        .dbg_state   (dbg_state)
    );

    // One vector = one instruction with its memory response and expected result.
    // delay: WAIT_RDY cycles before mem_ready is driven (255 = never);
    // lat:   edges from the first WAIT_RDY cycle until out_valid is seen.
    typedef struct {
        logic             ld;
        logic             st;
        logic [31:0]      addr;
        logic [63:0]      vdata;
        logic [VRD_W-1:0] vrd;
        logic [63:0]      rdata;
        int               delay;
        int               lat;
        logic             wr;
        logic             wb;
        logic [63:0]      data;
        logic             to;
        logic             ill;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        in_addr     = '0;
        in_vdata    = '0;
        in_vrd      = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        logic hold_ok;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        in_valid    = 1'b1;
        in_is_load  = v.ld;
        in_is_store = v.st;
        in_addr     = v.addr;
        in_vdata    = v.vdata;
        in_vrd      = v.vrd;
        tick();
        in_valid    = 1'b0;
        in_is_load  = 1'b0;
        in_is_store = 1'b0;
        if (v.ld == v.st) begin
            chk("nonmem_out_valid", 64'(out_valid), 64'd1);
            chk("nonmem_wb_en", 64'(out_wb_en), 64'd0);
            chk("nonmem_no_start", 64'(mem_start), 64'd0);
            chk("nonmem_err_illegal", 64'(err_illegal), 64'(v.ill));
            chk("nonmem_err_timeout", 64'(err_timeout), 64'(v.to));
            tick();
            chk("nonmem_pulse_end", 64'(out_valid), 64'd0);
            chk("nonmem_in_ready", 64'(in_ready), 64'd1);
        end else begin
            chk("issue_start", 64'(mem_start), 64'd1);
            chk("issue_in_ready", 64'(in_ready), 64'd0);
            chk("issue_addr", 64'(mem_addr), 64'(v.addr));
            chk("issue_wdata", mem_wdata, v.vdata);
            chk("issue_wr_en", 64'(mem_wr_en), 64'(v.wr));
            tick();
            n       = 0;
            hold_ok = 1'b1;
            while (!out_valid && n < 300) begin
                if (mem_start || in_ready || mem_addr !== v.addr ||
                    mem_wdata !== v.vdata || mem_wr_en !== v.wr) hold_ok = 1'b0;
                mem_ready = (n == v.delay);
                mem_rdata = (n == v.delay) ? v.rdata : 64'h0;
                tick();
                n++;
            end
            mem_ready = 1'b0;
            mem_rdata = '0;
            chk("wait_hold_stall", 64'(hold_ok), 64'd1);
            chk("resp_latency", 64'(n), 64'(v.lat));
            chk("resp_out_valid", 64'(out_valid), 64'd1);
            chk("resp_wb_en", 64'(out_wb_en), 64'(v.wb));
            chk("resp_data", out_data, v.data);
            chk("resp_vrd", 64'(out_vrd), 64'(v.vrd));
            chk("resp_err_timeout", 64'(err_timeout), 64'(v.to));
            chk("resp_err_illegal", 64'(err_illegal), 64'(v.ill));
            chk("resp_in_ready", 64'(in_ready), 64'd0);
            chk("resp_wr_en_held", 64'(mem_wr_en), 64'(v.wr));
            tick();
            chk("post_out_valid", 64'(out_valid), 64'd0);
            chk("post_data_hold", out_data, v.data);
            chk("post_vrd_hold", 64'(out_vrd), 64'(v.vrd));
            chk("post_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    initial begin
        //                ld    st    addr           vdata                   vrd   rdata                   dly lat wr    wb    data                    to    ill
        vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 64'h0,                3'd5, 64'hDEADBEEF_12345678, 3,  4,  1'b0, 1'b1, 64'hDEADBEEF_12345678, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0040, 64'hAAAA5555_0F0F0F0F, 3'd2, 64'h0,                2,  3,  1'b1, 1'b0, 64'h0,                1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0999, 64'h0,                3'd1, 64'h0,                0,  0,  1'b0, 1'b0, 64'h0,                1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 64'h0,                3'd7, 64'h01234567_89ABCDEF, 0,  1,  1'b0, 1'b1, 64'h01234567_89ABCDEF, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 64'h0,                3'd3, 64'hFFFF,             255, 16, 1'b0, 1'b0, 64'h0,                1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_0104, 64'h0,                3'd1, 64'h11112222_33334444, 15, 16, 1'b0, 1'b1, 64'h11112222_33334444, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'h0000_0500, 64'h0,                3'd6, 64'h0,                0,  0,  1'b0, 1'b0, 64'h0,                1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 32'h0000_0080, 64'h12345678_9ABCDEF0, 3'd4, 64'h0,                1,  2,  1'b1, 1'b0, 64'h0,                1'b1, 1'b1};

        // ---------------- reset ----------------
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_mem_start", 64'(mem_start), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_err", 64'({err_timeout, err_illegal}), 64'd0);

        // mem_ready outside WAIT_RDY must do nothing
        mem_ready = 1'b1;
        mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        tick();
        chk("stray_ready_out_valid", 64'(out_valid), 64'd0);
        chk("stray_ready_data", out_data, 64'd0);
        chk("stray_ready_in_ready", 64'(in_ready), 64'd1);
        mem_ready = 1'b0;
        mem_rdata = '0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // ---------------- reset in WAIT_RDY ----------------
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_addr    = 32'h0000_0700;
        in_vrd     = 3'd5;
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 64'(in_ready), 64'd1);
        chk("arst_mem_addr", 64'(mem_addr), 64'd0);
        chk("arst_mem_wr_start", 64'({mem_wr_en, mem_start}), 64'd0);
        chk("arst_out", 64'({out_valid, out_wb_en, out_vrd}), 64'd0);
        chk("arst_out_data", out_data, 64'd0);
        chk("arst_err_cleared", 64'({err_timeout, err_illegal}), 64'd0);
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 64'hCAFE_F00D_CAFE_F00D;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        tick();
        chk("arst_late_ready_no_valid", 64'(out_valid), 64'd0);
        chk("arst_late_ready_data", out_data, 64'd0);
        chk("arst_idle_in_ready", 64'(in_ready), 64'd1);

        // ---------------- back-to-back loads, in_valid held ----------------
        in_valid   = 1'b1;
        in_is_load = 1'b1;
        in_addr    = 32'h0000_0010;
        in_vrd     = 3'd4;
        tick();
        chk("b2b_issue1", 64'({mem_start, in_ready}), 64'b10);
        tick();
        chk("b2b_wait1_stall", 64'(in_ready), 64'd0);
        mem_ready = 1'b1;
        mem_rdata = 64'h0000_0000_0000_00A1;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("b2b_resp1", 64'({out_valid, out_wb_en, in_ready}), 64'b110);
        chk("b2b_resp1_data", out_data, 64'hA1);
        in_addr = 32'h0000_0020;
        in_vrd  = 3'd6;
        tick();
        chk("b2b_idle_accept", 64'({in_ready, out_valid}), 64'b10);
        tick();
        in_valid   = 1'b0;
        in_is_load = 1'b0;
        chk("b2b_issue2", 64'({mem_start, in_ready}), 64'b10);
        chk("b2b_issue2_addr", 64'(mem_addr), 64'h20);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 64'h0000_0000_0000_00B2;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        chk("b2b_resp2", 64'({out_valid, out_wb_en}), 64'b11);
        chk("b2b_resp2_vrd", 64'(out_vrd), 64'd6);
        chk("b2b_resp2_data", out_data, 64'hB2);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
